exe_mem_stage: RTL and testbench
================================

# exe_mem_stage

Parametrised pipeline-stage register: the generalised successor of the fixed EXE/MEM latch. It carries a control field and a data field between two pipeline stages with a valid/ready handshake, synchronous flush (bubble insertion), an optional 2-entry skid buffer that registers the upstream ready path, and a saturating stall counter. It is instantiated between EXE and MEM, and is reusable for any other stage boundary.

## Interface

Parameters:
- CTRL_W, 8, width of the control field (RAM_en, RAM_op, WB_DATA_op, REG_op, ... packed by the instantiator)
- DATA_W, 68, width of the data field (IH, PC, ALU data, RAM write data, WB address packed)
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value that means NOP; presented whenever the stage holds no valid beat
- SKID, 1, 1 selects the 2-entry skid buffer (registered in_ready); 0 selects a single register (combinational in_ready)
- CNT_W, 16, width of the stall counter

Ports:
- clk_50MHz  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream data field
- flush  in  1  synchronous kill of all held and incoming beats
- out_valid  out  1  beat present to downstream
- out_ready  in  1  downstream accepts a beat this cycle
- out_ctrl  out  CTRL_W  control field of the head beat; CTRL_BUBBLE when out_valid=0
- out_data  out  DATA_W  data field of the head beat; 0 after reset or flush, otherwise last value held
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating

## Operation

- In-transfer: in_valid & in_ready at the edge. Out-transfer: out_valid & out_ready at the edge.
- Storage: main register (M) drives the outputs. Skid register (S) exists only when SKID=1.
- SKID=0: in_ready = ~M.valid | out_ready (combinational). On an in-transfer, M loads the input; on an out-transfer without an in-transfer, M.valid clears.
- SKID=1: in_ready = ~S.valid, taken from a flop, with no combinational path from out_ready. The register pair behaves as follows:
  - M empty, or M emptying this cycle (out-transfer): an incoming beat loads into M.
  - M full and not emptying: an incoming beat loads into S.
  - out-transfer while S is valid: S moves to M and S clears. A simultaneous in-transfer cannot occur, because in_ready=0.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.
- Flush has priority over everything else in the same cycle:
  - M.valid and S.valid clear.
  - out_ctrl becomes CTRL_BUBBLE and out_data becomes 0.
  - Any beat in-transferring that cycle is discarded.
  - An out-transfer in the flush cycle still counts as delivered.
- out_ctrl is forced to CTRL_BUBBLE whenever M.valid=0, so downstream decoding never sees stale control.
- stall_cnt increments by 1 each cycle with out_valid & ~out_ready, stops at 2^CNT_W-1, and is cleared only by rst. Flush does not clear it.

## Timing

- Reset (asynchronous, immediate) drives:
  - out_valid = 0
  - out_ctrl = CTRL_BUBBLE
  - out_data = 0
  - in_ready = 1
  - stall_cnt = 0
  - M.valid = S.valid = 0
- Reset asserted mid-transfer drops all beats. The first accept is possible on the first rising edge after rst deasserts.
- Latency: a beat accepted at edge N appears on out_* after edge N and is deliverable at edge N+1.
- Throughput is 1 beat/cycle with out_ready held at 1, for both SKID settings.
- SKID=1 in_ready timing:
  - in_ready falls one cycle after the stall begins, when the second beat lands in S.
  - in_ready rises the cycle after the out-transfer that drains S.
- Buffer capacity before back-pressure is 2 beats (SKID=1) or 1 beat (SKID=0).
- Flush at edge N: out_valid=0 after edge N; a new beat may be accepted at edge N+1.

## Test plan

- Reset release, out_ready=1, SKID=1, beats ctrl=0x11..0x14 / data=1..4 on consecutive cycles -> out_valid high from the cycle after the first accept, same order, one per cycle, in_ready stays 1, stall_cnt=0.
- SKID=1, out_ready=0 for 5 cycles while in_valid=1 with beats A,B,C -> A in M and B in S, in_ready falls after B, C held upstream, stall_cnt=5 (4 if the stall starts one cycle later). Releasing out_ready yields A,B,C in order with no gaps.
- SKID=0, same stimulus -> in_ready = out_ready while full, only A buffered, output order A,B,C.
- Flush asserted while M and S hold A,B and in_valid=1 with C -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, A/B/C never appear; D presented next is delivered.
- CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt stops at 15, unaffected by flush, cleared only by rst.
- rst pulsed asynchronously between edges while holding 2 beats -> outputs take their reset values immediately, no beat appears afterward, in_ready=1.

Source files
------------

// File: rtl/exe_mem_stage.sv
`timescale 1ns/1ps
// exe_mem_stage
// Pipeline-stage register carrying a control field and a data field between
// two stages with a valid/ready handshake. It also provides:
//   - synchronous flush, which inserts a bubble;
//   - an optional 2-entry skid buffer that registers the upstream ready path;
//   - a saturating counter of output stall cycles.
//
// Ports:
//   clk_50MHz  in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   upstream beat present
//   in_ready   out  stage accepts a beat this cycle
//   in_ctrl    in   upstream control field  [CTRL_W]
//   in_data    in   upstream data field     [DATA_W]
//   flush      in   synchronous kill of held and incoming beats
//   out_valid  out  beat present to downstream
//   out_ready  in   downstream accepts a beat this cycle
//   out_ctrl   out  head control field, CTRL_BUBBLE when out_valid=0
//   out_data   out  head data field, 0 after reset/flush, else last value held
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
module exe_mem_stage #(
  parameter int                CTRL_W      = 8,
  parameter int                DATA_W      = 68,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Main register: always the head of the stage, drives the outputs.
  logic              r_m_valid;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_m_valid & out_ready;

  assign out_valid = r_m_valid;
  // Never expose stale control to the downstream decoder.
  assign out_ctrl  = r_m_valid ? r_m_ctrl : CTRL_BUBBLE;
  assign out_data  = r_m_data;
  assign stall_cnt = r_stall_cnt;

  generate
    if (SKID != 0) begin : g_skid
      // Skid register catches the one beat that arrives while M is stalled.
      logic              r_s_valid;
      logic [CTRL_W-1:0] r_s_ctrl;
      logic [DATA_W-1:0] r_s_data;

      // Ready depends only on a flop, so out_ready never reaches in_ready.
      assign in_ready = ~r_s_valid;

      always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
          r_m_valid <= 1'b0;
          r_m_ctrl  <= CTRL_BUBBLE;
          r_m_data  <= '0;
          r_s_valid <= 1'b0;
          r_s_ctrl  <= CTRL_BUBBLE;
          r_s_data  <= '0;
        end else if (flush) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_s_valid <= 1'b0;
        end else if (w_out_xfer && r_s_valid) begin
          // in_ready is low here, so no incoming beat competes with S.
          r_m_ctrl  <= r_s_ctrl;
          r_m_data  <= r_s_data;
          r_s_valid <= 1'b0;
        end else if (w_in_xfer && (!r_m_valid || w_out_xfer)) begin
          r_m_valid <= 1'b1;
          r_m_ctrl  <= in_ctrl;
          r_m_data  <= in_data;
        end else if (w_in_xfer) begin
          // M full and held: park the beat behind it.
          r_s_valid <= 1'b1;
          r_s_ctrl  <= in_ctrl;
          r_s_data  <= in_data;
        end else if (w_out_xfer) begin
          r_m_valid <= 1'b0;
        end
      end
    end else begin : g_single
      assign in_ready = ~r_m_valid | out_ready;

      always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
          r_m_valid <= 1'b0;
          r_m_ctrl  <= CTRL_BUBBLE;
          r_m_data  <= '0;
        end else if (flush) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
        end else if (w_in_xfer) begin
          r_m_valid <= 1'b1;
          r_m_ctrl  <= in_ctrl;
          r_m_data  <= in_data;
        end else if (w_out_xfer) begin
          r_m_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
`timescale 1ns/1ps
// Testbench for exe_mem_stage: one SKID=1 instance (CNT_W=4, non-zero bubble)
// and one SKID=0 instance, each tracked by a FIFO scoreboard.
module tb_exe_mem_stage;
  localparam int CW = 8;
  localparam int DW = 68;
  localparam logic [CW-1:0] BUB_S = 8'hA5;
  localparam logic [CW-1:0] BUB_N = 8'h00;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // SKID=1 instance
  logic          sv = 1'b0, sr = 1'b0, sf = 1'b0;
  logic [CW-1:0] sc = '0;
  logic [DW-1:0] sd = '0;
  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_cnt;

  // SKID=0 instance
  logic          nv = 1'b0, nr = 1'b0, nf = 1'b0;
  logic [CW-1:0] nc = '0;
  logic [DW-1:0] nd = '0;
  logic          n_in_ready, n_out_valid;
  logic [CW-1:0] n_out_ctrl;
  logic [DW-1:0] n_out_data;
  logic [15:0]   n_cnt;

  exe_mem_stage #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB_S), .SKID(1), .CNT_W(4)) u_skid (
    .clk_50MHz(clk), .rst(rst),
    .in_valid(sv), .in_ready(s_in_ready), .in_ctrl(sc), .in_data(sd),
    .flush(sf),
    .out_valid(s_out_valid), .out_ready(sr), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_cnt)
  );

  exe_mem_stage #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB_N), .SKID(0), .CNT_W(16)) u_single (
    .clk_50MHz(clk), .rst(rst),
    .in_valid(nv), .in_ready(n_in_ready), .in_ctrl(nc), .in_data(nd),
    .flush(nf),
    .out_valid(n_out_valid), .out_ready(nr), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
    .stall_cnt(n_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  beat_t q_s[$];
  beat_t q_n[$];

  // Scoreboards: compare the head at each out-transfer, then account for
  // the beat (if any) entering at the coming edge.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      q_s.delete();
    end else begin
      check("s_valid", 96'(s_out_valid), 96'(q_s.size() != 0));
      if (!s_out_valid) check("s_bubble", 96'(s_out_ctrl), 96'(BUB_S));
      if (s_out_valid && sr && q_s.size() != 0) begin
        b = q_s.pop_front();
        check("s_ctrl", 96'(s_out_ctrl), 96'(b.c));
        check("s_data", 96'(s_out_data), 96'(b.d));
        $display("[TB] skid   out ctrl=%h data=%h", s_out_ctrl, s_out_data);
      end
      if (sf) q_s.delete();
      else if (sv && s_in_ready) q_s.push_back({sc, sd});
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      q_n.delete();
    end else begin
      check("n_valid", 96'(n_out_valid), 96'(q_n.size() != 0));
      if (!n_out_valid) check("n_bubble", 96'(n_out_ctrl), 96'(BUB_N));
      if (n_out_valid && nr && q_n.size() != 0) begin
        b = q_n.pop_front();
        check("n_ctrl", 96'(n_out_ctrl), 96'(b.c));
        check("n_data", 96'(n_out_data), 96'(b.d));
        $display("[TB] single out ctrl=%h data=%h", n_out_ctrl, n_out_data);
      end
      if (nf) q_n.delete();
      else if (nv && n_in_ready) q_n.push_back({nc, nd});
    end
  end

  task automatic step_s(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic r, input logic f);
    @(posedge clk); #1;
    sv = v; sc = c; sd = d; sr = r; sf = f;
    @(negedge clk);
  endtask

  task automatic step_n(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic r, input logic f);
    @(posedge clk); #1;
    nv = v; nc = c; nd = d; nr = r; nf = f;
    @(negedge clk);
  endtask

  // Present a beat until in_ready is seen with it (accepted at the next edge).
  task automatic hold_s(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r);
    logic ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step_s(1'b1, c, d, r, 1'b0);
      ok = s_in_ready;
    end
    check("s_accept", 96'(ok), 96'(1));
  endtask

  task automatic hold_n(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r);
    logic ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step_n(1'b1, c, d, r, 1'b0);
      ok = n_in_ready;
    end
    check("n_accept", 96'(ok), 96'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    sv = 0; sr = 0; sf = 0; nv = 0; nr = 0; nf = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #5;
    check("rst_s_valid", 96'(s_out_valid), 96'(0));
    check("rst_s_ctrl",  96'(s_out_ctrl),  96'(BUB_S));
    check("rst_s_data",  96'(s_out_data),  96'(0));
    check("rst_s_ready", 96'(s_in_ready),  96'(1));
    check("rst_s_cnt",   96'(s_cnt),       96'(0));
    check("rst_n_ready", 96'(n_in_ready),  96'(1));
    check("rst_n_cnt",   96'(n_cnt),       96'(0));
    do_reset();

    // Streaming at full rate through the skid stage
    for (int i = 0; i < 4; i++) begin
      step_s(1'b1, CW'(8'h11 + i), DW'(i + 1), 1'b1, 1'b0);
      check("t1_ready", 96'(s_in_ready), 96'(1));
      if (i > 0) check("t1_head", 96'(s_out_ctrl), 96'(8'h11 + i - 1));
    end
    step_s(1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_last", 96'(s_out_ctrl), 96'(8'h14));
    step_s(1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_hold_data", 96'(s_out_data), 96'(4));
    check("t1_cnt", 96'(s_cnt), 96'(0));

    // Skid stall: A in M, B in S, C held upstream
    do_reset();
    step_s(1'b1, 8'h21, DW'(68'h21), 1'b0, 1'b0);
    check("t2_ready_a", 96'(s_in_ready), 96'(1));
    step_s(1'b1, 8'h22, DW'(68'h22), 1'b0, 1'b0);
    check("t2_ready_b", 96'(s_in_ready), 96'(1));
    for (int i = 0; i < 3; i++) begin
      step_s(1'b1, 8'h23, DW'(68'h23), 1'b0, 1'b0);
      check("t2_ready_c", 96'(s_in_ready), 96'(0));
    end
    hold_s(8'h23, DW'(68'h23), 1'b1);
    check("t2_cnt", 96'(s_cnt), 96'(4));
    step_s(1'b0, '0, '0, 1'b1, 1'b0);
    step_s(1'b0, '0, '0, 1'b1, 1'b0);

    // Single-register stall: in_ready follows out_ready while full
    do_reset();
    step_n(1'b1, 8'h21, DW'(68'h21), 1'b0, 1'b0);
    check("t3_ready_a", 96'(n_in_ready), 96'(1));
    for (int i = 0; i < 4; i++) begin
      step_n(1'b1, 8'h22, DW'(68'h22), 1'b0, 1'b0);
      check("t3_ready_full", 96'(n_in_ready), 96'(nr));
    end
    hold_n(8'h22, DW'(68'h22), 1'b1);
    hold_n(8'h23, DW'(68'h23), 1'b1);
    step_n(1'b0, '0, '0, 1'b1, 1'b0);
    step_n(1'b0, '0, '0, 1'b1, 1'b0);
    check("t3_cnt", 96'(n_cnt), 96'(4));

    // Flush with M and S full and C presented; D follows
    do_reset();
    step_s(1'b1, 8'h41, DW'(68'hA41), 1'b0, 1'b0);
    step_s(1'b1, 8'h42, DW'(68'hA42), 1'b0, 1'b0);
    step_s(1'b1, 8'h43, DW'(68'hA43), 1'b0, 1'b1);
    step_s(1'b1, 8'h44, DW'(68'hA44), 1'b1, 1'b0);
    check("t4_valid", 96'(s_out_valid), 96'(0));
    check("t4_ctrl",  96'(s_out_ctrl),  96'(BUB_S));
    check("t4_data",  96'(s_out_data),  96'(0));
    check("t4_ready", 96'(s_in_ready),  96'(1));
    step_s(1'b0, '0, '0, 1'b1, 1'b0);
    check("t4_d_ctrl", 96'(s_out_ctrl), 96'(8'h44));
    step_s(1'b0, '0, '0, 1'b1, 1'b0);

    // Single register: out-transfer during flush is delivered, input dropped
    step_n(1'b1, 8'h31, DW'(68'h31), 1'b1, 1'b0);
    step_n(1'b1, 8'h32, DW'(68'h32), 1'b1, 1'b1);
    step_n(1'b0, '0, '0, 1'b1, 1'b0);
    check("t4n_valid", 96'(n_out_valid), 96'(0));
    check("t4n_data",  96'(n_out_data),  96'(0));

    // Counter saturation, immune to flush, cleared by reset
    do_reset();
    step_s(1'b1, 8'h51, DW'(68'h51), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step_s(1'b0, '0, '0, 1'b0, 1'b0);
    check("t5_sat", 96'(s_cnt), 96'(15));
    step_s(1'b0, '0, '0, 1'b0, 1'b1);
    step_s(1'b0, '0, '0, 1'b0, 1'b0);
    check("t5_flush", 96'(s_cnt), 96'(15));
    do_reset();
    check("t5_rst", 96'(s_cnt), 96'(0));

    // Asynchronous reset between edges while holding two beats
    step_s(1'b1, 8'h61, DW'(68'h61), 1'b0, 1'b0);
    step_s(1'b1, 8'h62, DW'(68'h62), 1'b0, 1'b0);
    @(posedge clk); #1;
    sv = 1'b0;
    #3 rst = 1'b1;
    q_s.delete();
    #1;
    check("t6_valid", 96'(s_out_valid), 96'(0));
    check("t6_ctrl",  96'(s_out_ctrl),  96'(BUB_S));
    check("t6_data",  96'(s_out_data),  96'(0));
    check("t6_ready", 96'(s_in_ready),  96'(1));
    check("t6_cnt",   96'(s_cnt),       96'(0));
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_s(1'b0, '0, '0, 1'b1, 1'b0);
      check("t6_empty", 96'(s_out_valid), 96'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
